imem_fetch_arbiter: RTL

Round-robin arbiter that shares one 64-bit synchronous instruction-memory read port among NUM_REQ fetch units. It accepts one fetch request per cycle, sends the 8-byte-aligned address to memory, and tracks each in-flight read through a fixed-latency pipeline. When the data returns, it is routed back to the requester that issued it. A requester can flush its own in-flight reads on a branch or prediction redirect, so stale bundles never reach it.

---
 rtl/imem_fetch_arbiter_if.sv | 25 ++
 rtl/imem_fetch_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter_if.sv
// rtl/imem_fetch_arbiter_if.sv - requester, response and memory-port bundle of the fetch arbiter
interface imem_fetch_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_flush;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [63:0]           rsp_data;
  logic                  mem_en;
  logic [31:0]           mem_addr;
  logic [63:0]           mem_rdata;
  logic [31:0]           gnt_count;

  modport master (
    output req_valid, req_addr, req_flush, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_en, mem_addr, gnt_count
  );

  modport slave (
    input  req_valid, req_addr, req_flush, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_en, mem_addr, gnt_count
  );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - round-robin sharing of one fixed-latency 64-bit instruction-memory read port
module imem_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_fetch_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic               gnt_any;
  logic [IW-1:0]      gnt_id;
  logic [IW:0]        scan;
  logic [31:0]        gnt_addr;
  logic [MEM_LAT-1:0] stg_valid;
  logic [IW-1:0]      stg_id [MEM_LAT];
  logic               last_live;

  assign eligible = bus.req_valid & ~bus.req_flush;

  // rr_ptr and k are both below NUM_REQ, so one subtraction wraps the scan index
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) begin
        scan = scan - (IW+1)'(NUM_REQ);
      end
      if (!gnt_any && eligible[scan[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IW'(i)) begin
        gnt_addr = bus.req_addr[32*i +: 32];
      end
    end
    bus.req_ready = '0;
    if (gnt_any) begin
      bus.req_ready[gnt_id] = 1'b1;
    end
    bus.mem_en   = gnt_any;
    bus.mem_addr = gnt_any ? {gnt_addr[31:3], 3'b000} : 32'd0;
  end

  // A granted requester never flushes this cycle, so stage 0 loads unmasked
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      bus.gnt_count <= '0;
      stg_valid     <= '0;
      for (int s = 0; s < MEM_LAT; s++) begin
        stg_id[s] <= '0;
      end
    end else begin
      if (gnt_any) begin
        rr_ptr        <= (gnt_id == IW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        bus.gnt_count <= bus.gnt_count + 32'd1;
      end
      stg_valid[0] <= gnt_any;
      stg_id[0]    <= gnt_id;
      for (int s = 1; s < MEM_LAT; s++) begin
        stg_valid[s] <= stg_valid[s-1] && !bus.req_flush[stg_id[s-1]];
        stg_id[s]    <= stg_id[s-1];
      end
    end
  end

  // Responses are also held off during reset so a dropped read never surfaces
  assign last_live = rst_n && stg_valid[MEM_LAT-1] && !bus.req_flush[stg_id[MEM_LAT-1]];

  always_comb begin
    bus.rsp_valid = '0;
    if (last_live) begin
      bus.rsp_valid[stg_id[MEM_LAT-1]] = 1'b1;
    end
    bus.rsp_data = last_live ? bus.mem_rdata : 64'd0;
  end
endmodule
